display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Scheduler for the 4-digit multiplexed 7-segment display. It time-slices the single shared segment bus across the four digits and drives active-low anodes. It adds PWM brightness and leading-zero blanking. New BCD data enters through a valid/ready handshake and is committed only at frame boundaries, so a frame never shows a mix of old and new data. It sits between the binary-to-BCD stage and an external BCD-to-segment decoder.

Parameters:
PRESCALE_LOG2, 16, log2 of clock cycles per digit slot (slot = 2^PRESCALE_LOG2 cycles); minimum 3
DIGITS, 4, number of digits; fixed at 4 (not user-overridable)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
data_in  in  16  four BCD nibbles; [15:12] is digit 3 (MSD), [3:0] is digit 0 (LSD)
data_valid  in  1  data_in offered
data_ready  out  1  pending slot empty; transfer occurs when data_valid && data_ready
brightness  in  3  PWM duty: 0 = 1/8 on, 7 = 8/8 on
lzb_en  in  1  leading-zero blanking enable
ANODE  out  4  active-low one-hot digit enable
digit_out  out  4  BCD nibble of the currently scanned digit, to the decoder
blank  out  1  high when no anode is active
frame_tick  out  1  one-cycle pulse at each frame end

Behaviour:
- Counters:
  - cnt is PRESCALE_LOG2 bits, free-running.
  - slot_end = (cnt == all ones).
  - idx is 2 bits; it increments on slot_end and wraps 3->0.
  - frame_end = slot_end && idx == 3.
- Storage:
  - active_data, 16 bits: the value being displayed.
  - pend_data, 16 bits, plus pend_full flag: one-entry pending buffer.
- Handshake:
  - data_ready = ~pend_full (combinational).
  - On accept with !frame_end: pend_data <= data_in; pend_full <= 1.
  - On accept on a frame_end cycle: active_data <= data_in directly; pend_full stays 0.
  - On frame_end with pend_full=1 (no accept is possible that cycle): active_data <= pend_data; pend_full <= 0.
  - Maximum latency from accept to display is one frame (4 slots).
  - The producer holds data_in stable while data_valid && !data_ready.
- Leading-zero blanking (lzb_en=1), evaluated on active_data:
  - d3 is blanked if d3 == 0.
  - d2 is blanked if d3 == 0 and d2 == 0.
  - d1 is blanked if d3, d2 and d1 are all 0.
  - d0 is never blanked.
  - With lzb_en=0, no digit is blanked.
- Non-BCD nibbles (A-F) pass through unchanged and are not blanked.
- PWM: anode is on when cnt[PRESCALE_LOG2-1 -: 3] <= brightness. brightness is sampled live.
- Outputs, all registered (one-cycle output stage, state from the previous cycle):
  - on = pwm_on && !lzb_blank(idx).
  - ANODE <= on ? ~(4'b0001 << idx) : 4'b1111.
  - digit_out <= active_data nibble[idx], even when blanked.
  - blank <= !on.
  - frame_tick <= frame_end.
- Reset (synchronous, overrides all):
  - cnt=0, idx=0, active_data=0, pend_full=0.
  - ANODE=4'b1111, digit_out=0, blank=1, frame_tick=0, data_ready=1.
  - A reset asserted mid-frame or with data pending discards pending data; scanning restarts at digit 0, slot start.
- Anodes are never more than one-hot; all-ones is the only idle pattern.

Test Plan:
(All scenarios use PRESCALE_LOG2=3: slot = 8 cycles, frame = 32 cycles.)
1. Reset check: assert rst 2 cycles, brightness=7, lzb_en=0 -> ANODE=1111, blank=1, data_ready=1. One cycle after release: ANODE=1110, digit_out=0, held for 8 cycles, then 1101, 1011, 0111; frame_tick pulses every 32 cycles.
2. Load and commit: offer 16'h1234 mid-frame -> data_ready drops next cycle; at the next frame_tick data_ready returns to 1. The following frame shows digit_out 4,3,2,1 with ANODE 1110,1101,1011,0111, 8 cycles each.
3. Back-pressure: offer 16'h1111 then 16'h2222 in the same frame -> 0x2222 stalls (data_ready=0) until frame_end. 0x1111 is displayed for one frame, then 0x2222. An offer coinciding with frame_end commits directly and shows in the next frame.
4. Brightness: brightness=0 -> ANODE active for 1 of 8 cycles per slot (blank=1 for the other 7). brightness=3 -> 4 of 8. brightness=7 -> 8 of 8.
5. Blanking, lzb_en=1:
   - 16'h0005 -> digits 3, 2 and 1 have ANODE=1111, blank=1; digit 0 shows 5.
   - 16'h0000 -> only digit 0 is lit, showing 0.
   - 16'h0105 -> only digit 3 is blanked.
   - Setting lzb_en=0 on 16'h0005 -> all four digits are lit.
6. Reset mid-operation: pending 16'h9876 outstanding while scanning digit 2; assert rst for 1 cycle -> outputs return to reset values next edge. Display shows 0000 from digit 0 onward, and 0x9876 is never shown.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Scan scheduler for a 4-digit multiplexed 7-segment display.
// The single shared segment bus is time-sliced across the four digits. Each
// digit owns one slot of 2^PRESCALE_LOG2 clock cycles. New BCD data is taken
// through a valid/ready handshake into a one-entry pending buffer and is only
// committed to the displayed value at a frame boundary, so one frame never
// mixes old and new digits. PWM brightness and leading-zero blanking gate the
// active-low anodes. Every output is registered.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   data_in     four BCD nibbles, [15:12] = digit 3 (MSD), [3:0] = digit 0
//   data_valid  producer offers data_in
//   data_ready  pending slot empty (transfer when data_valid && data_ready)
//   brightness  PWM duty, 0 = 1/8 on ... 7 = 8/8 on, sampled live
//   lzb_en      leading-zero blanking enable
//   ANODE       active-low one-hot digit enable, 4'b1111 when idle
//   digit_out   BCD nibble of the digit being scanned, to the segment decoder
//   blank       high when no anode is active
//   frame_tick  one-cycle pulse after each frame end
// -----------------------------------------------------------------------------
module display_scan_ctrl #(
    parameter int PRESCALE_LOG2 = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        data_valid,
    output logic        data_ready,
    input  logic [2:0]  brightness,
    input  logic        lzb_en,
    output logic [3:0]  ANODE,
    output logic [3:0]  digit_out,
    output logic        blank,
    output logic        frame_tick
);

    localparam int DIGITS    = 4;
    localparam int IDX_W     = $clog2(DIGITS);

    // Leading-zero blanking: a digit is blanked only when it and every more
    // significant digit are zero. Digit 0 always shows, so "0" stays visible.
    // Non-BCD nibbles are non-zero and therefore never blank.
    function automatic logic lzb_blank(input logic [15:0] d,
                                       input logic [IDX_W-1:0] i,
                                       input logic en);
        logic b;
        b = 1'b0;
        if (en) begin
            case (i)
                2'd3:    b = (d[15:12] == 4'd0);
                2'd2:    b = (d[15:12] == 4'd0) && (d[11:8] == 4'd0);
                2'd1:    b = (d[15:12] == 4'd0) && (d[11:8] == 4'd0)
                             && (d[7:4] == 4'd0);
                default: b = 1'b0;
            endcase
        end else begin
            b = 1'b0;
        end
        return b;
    endfunction

    logic [PRESCALE_LOG2-1:0] cnt_r;
    logic [IDX_W-1:0]         idx_r;
    logic [15:0]              active_data_r;
    logic [15:0]              pend_data_r;
    logic                     pend_full_r;

    logic                     slot_end_s;
    logic                     frame_end_s;
    logic                     accept_s;
    logic                     pwm_on_s;
    logic                     on_s;
    logic [3:0]               nibble_s;
    logic [3:0]               anode_r;
    logic [3:0]               digit_r;
    logic                     blank_r;
    logic                     frame_tick_r;

    assign slot_end_s  = &cnt_r;
    assign frame_end_s = slot_end_s && (idx_r == 2'd3);
    assign data_ready  = ~pend_full_r;
    assign accept_s    = data_valid && ~pend_full_r;

    // Slot timing and data staging; commits happen only at frame_end.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= {PRESCALE_LOG2{1'b0}};
            idx_r         <= {IDX_W{1'b0}};
            active_data_r <= 16'h0000;
            pend_data_r   <= 16'h0000;
            pend_full_r   <= 1'b0;
        end else begin
            cnt_r <= cnt_r + {{(PRESCALE_LOG2-1){1'b0}}, 1'b1};
            if (slot_end_s) begin
                idx_r <= idx_r + 2'd1;
            end
            if (frame_end_s) begin
                // An accept here implies the buffer was empty, so the new word
                // can bypass the buffer and still land exactly on the boundary.
                if (accept_s) begin
                    active_data_r <= data_in;
                end else if (pend_full_r) begin
                    active_data_r <= pend_data_r;
                    pend_full_r   <= 1'b0;
                end
            end else if (accept_s) begin
                pend_data_r <= data_in;
                pend_full_r <= 1'b1;
            end
        end
    end

    // PWM gate and digit selection for the current slot.
    always_comb begin
        pwm_on_s = 1'b0;
        nibble_s = 4'd0;
        on_s     = 1'b0;
        // Top three counter bits split the slot into eighths.
        if (cnt_r[PRESCALE_LOG2-1 -: 3] <= brightness) begin
            pwm_on_s = 1'b1;
        end else begin
            pwm_on_s = 1'b0;
        end
        case (idx_r)
            2'd0:    nibble_s = active_data_r[3:0];
            2'd1:    nibble_s = active_data_r[7:4];
            2'd2:    nibble_s = active_data_r[11:8];
            2'd3:    nibble_s = active_data_r[15:12];
            default: nibble_s = 4'd0;
        endcase
        on_s = pwm_on_s && !lzb_blank(active_data_r, idx_r, lzb_en);
    end

    // Registered output stage; anodes are one-hot active-low or all ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            anode_r      <= 4'b1111;
            digit_r      <= 4'd0;
            blank_r      <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            anode_r      <= on_s ? ~(4'b0001 << idx_r) : 4'b1111;
            digit_r      <= nibble_s;
            blank_r      <= !on_s;
            frame_tick_r <= frame_end_s;
        end
    end

    assign ANODE      = anode_r;
    assign digit_out  = digit_r;
    assign blank      = blank_r;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed self-checking bench for display_scan_ctrl with PRESCALE_LOG2 = 3
// (slot = 8 cycles, frame = 32 cycles). Outputs are sampled 1 time unit after
// each rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_ready;
    logic [2:0]  brightness;
    logic        lzb_en;
    logic [3:0]  ANODE;
    logic [3:0]  digit_out;
    logic        blank;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Lit anode pattern for each digit slot.
    logic [3:0] on_pat [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    display_scan_ctrl #(.PRESCALE_LOG2(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .brightness (brightness),
        .lzb_en     (lzb_en),
        .ANODE      (ANODE),
        .digit_out  (digit_out),
        .blank      (blank),
        .frame_tick (frame_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One full frame from its first output cycle; 'lit' marks unblanked digits.
    task automatic check_frame(input logic [15:0] val, input logic [3:0] lit);
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                chk("frame_anode", {12'h000, ANODE}, {12'h000, lit[i] ? on_pat[i] : 4'b1111});
                chk("frame_digit", {12'h000, digit_out}, {12'h000, val[4*i +: 4]});
                chk("frame_blank", {15'h0000, blank}, {15'h0000, !lit[i]});
                chk("frame_tick", {15'h0000, frame_tick}, {15'h0000, (i == 3 && c == 7)});
                data_valid = 1'b0;
            end
        end
    endtask

    // Offer at a frame start; value is displayed from the next frame start.
    task automatic load(input logic [15:0] val);
        data_in    = val;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        for (int n = 0; n < 31; n++) tick();
    endtask

    initial begin
        int on_cnt;
        rst        = 1'b1;
        data_in    = 16'h0000;
        data_valid = 1'b0;
        brightness = 3'd7;
        lzb_en     = 1'b0;

        // 1. reset state, then a plain frame of zeros
        tick();
        tick();
        chk("rst_anode", {12'h000, ANODE}, 16'h000F);
        chk("rst_blank", {15'h0000, blank}, 16'h0001);
        chk("rst_ready", {15'h0000, data_ready}, 16'h0001);
        chk("rst_digit", {12'h000, digit_out}, 16'h0000);
        chk("rst_tick", {15'h0000, frame_tick}, 16'h0000);
        rst = 1'b0;
        check_frame(16'h0000, 4'b1111);

        // 2. load mid-frame, commit at frame end
        for (int n = 0; n < 12; n++) tick();
        data_in    = 16'h1234;
        data_valid = 1'b1;
        chk("ld_ready_pre", {15'h0000, data_ready}, 16'h0001);
        tick();
        data_valid = 1'b0;
        chk("ld_ready_low", {15'h0000, data_ready}, 16'h0000);
        for (int n = 0; n < 18; n++) tick();
        chk("ld_ready_hold", {15'h0000, data_ready}, 16'h0000);
        chk("ld_old_digit", {12'h000, digit_out}, 16'h0000);
        tick();
        chk("ld_tick", {15'h0000, frame_tick}, 16'h0001);
        chk("ld_ready_back", {15'h0000, data_ready}, 16'h0001);
        check_frame(16'h1234, 4'b1111);

        // 3. back-pressure: second word stalls until frame end
        for (int n = 0; n < 4; n++) tick();
        data_in    = 16'h1111;
        data_valid = 1'b1;
        tick();
        data_in = 16'h2222;
        chk("bp_ready_low", {15'h0000, data_ready}, 16'h0000);
        for (int n = 0; n < 26; n++) tick();
        chk("bp_ready_stall", {15'h0000, data_ready}, 16'h0000);
        chk("bp_old_digit", {12'h000, digit_out}, 16'h0001);
        tick();
        chk("bp_tick", {15'h0000, frame_tick}, 16'h0001);
        chk("bp_ready_free", {15'h0000, data_ready}, 16'h0001);
        check_frame(16'h1111, 4'b1111);
        check_frame(16'h2222, 4'b1111);

        // 3b. offer on the frame_end cycle commits directly
        for (int n = 0; n < 31; n++) tick();
        data_in    = 16'h5678;
        data_valid = 1'b1;
        chk("fe_ready_pre", {15'h0000, data_ready}, 16'h0001);
        tick();
        data_valid = 1'b0;
        chk("fe_ready_post", {15'h0000, data_ready}, 16'h0001);
        chk("fe_tick", {15'h0000, frame_tick}, 16'h0001);
        check_frame(16'h5678, 4'b1111);

        // 4. brightness 0 / 3 / 7 on slots 0 / 1 / 2
        brightness = 3'd0;
        on_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("pwm0_anode", {12'h000, ANODE}, {12'h000, (c == 0) ? 4'b1110 : 4'b1111});
            chk("pwm0_blank", {15'h0000, blank}, {15'h0000, c != 0});
            if (blank == 1'b0) on_cnt++;
        end
        chk("pwm0_count", on_cnt[15:0], 16'd1);
        brightness = 3'd3;
        on_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("pwm3_anode", {12'h000, ANODE}, {12'h000, (c <= 3) ? 4'b1101 : 4'b1111});
            chk("pwm3_digit", {12'h000, digit_out}, 16'h0007);
            if (blank == 1'b0) on_cnt++;
        end
        chk("pwm3_count", on_cnt[15:0], 16'd4);
        brightness = 3'd7;
        on_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            chk("pwm7_anode", {12'h000, ANODE}, 16'h000B);
            if (blank == 1'b0) on_cnt++;
        end
        chk("pwm7_count", on_cnt[15:0], 16'd8);
        for (int n = 0; n < 8; n++) tick();

        // 5. leading-zero blanking
        lzb_en = 1'b1;
        load(16'h0005);
        check_frame(16'h0005, 4'b0001);
        load(16'h0000);
        check_frame(16'h0000, 4'b0001);
        load(16'h0105);
        check_frame(16'h0105, 4'b0111);
        load(16'h0A05);
        check_frame(16'h0A05, 4'b0111);
        load(16'h0005);
        lzb_en = 1'b0;
        check_frame(16'h0005, 4'b1111);

        // 6. reset while scanning digit 2 with 0x9876 pending
        for (int n = 0; n < 16; n++) tick();
        data_in    = 16'h9876;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        chk("mr_pending", {15'h0000, data_ready}, 16'h0000);
        tick();
        tick();
        chk("mr_digit2", {12'h000, ANODE}, 16'h000B);
        rst = 1'b1;
        tick();
        chk("mr_anode", {12'h000, ANODE}, 16'h000F);
        chk("mr_blank", {15'h0000, blank}, 16'h0001);
        chk("mr_digit", {12'h000, digit_out}, 16'h0000);
        chk("mr_tick", {15'h0000, frame_tick}, 16'h0000);
        chk("mr_ready", {15'h0000, data_ready}, 16'h0001);
        rst = 1'b0;
        check_frame(16'h0000, 4'b1111);
        check_frame(16'h0000, 4'b1111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
